// File: rtl/ysyx_23060208_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060208_mem_arbiter
//
// Two-master, one-slave AXI-lite read arbiter. The IFU fetch path and the LSU
// load path share the single SRAM read port. One transaction is in flight at
// a time. When both masters request in the same idle cycle, the master that
// was not granted last wins (round robin).
//
// Timing: a request is seen in IDLE and forwarded from the next cycle. In the
// AR and R states the AR and R channels are combinational pass-throughs
// between the granted master and the SRAM, so the only latency the arbiter
// adds is the IDLE cycle. With a zero-latency slave the best case is one
// transaction every three cycles (IDLE, AR, R).
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active low (0 = reset)
//   ifu_ar*/ifu_r* IFU read master: address request in, data/response out
//   lsu_ar*/lsu_r* LSU read master: address request in, data/response out
//   sram_ar*       address request toward the SRAM
//   sram_r*        read data/response from the SRAM, sram_rready back to it
//
// The non-granted master always sees arready=0, rvalid=0, rdata=0, rresp=0,
// and its arvalid may stay high for as long as it likes.
// ---------------------------------------------------------------------------
module ysyx_23060208_mem_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  // IFU read master
  input  logic [DATA_WIDTH-1:0] ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic                  ifu_rvalid,
  output logic [1:0]            ifu_rresp,
  input  logic                  ifu_rready,

  // LSU read master
  input  logic [DATA_WIDTH-1:0] lsu_araddr,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  lsu_rvalid,
  output logic [1:0]            lsu_rresp,
  input  logic                  lsu_rready,

  // SRAM read slave
  output logic [DATA_WIDTH-1:0] sram_araddr,
  output logic                  sram_arvalid,
  input  logic                  sram_arready,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  input  logic                  sram_rvalid,
  input  logic [1:0]            sram_rresp,
  output logic                  sram_rready
);

  // The state encodes both the phase of the transaction and which master
  // owns it, so the grant needs no separate register.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFU_AR = 3'd1,
    IFU_R  = 3'd2,
    LSU_AR = 3'd3,
    LSU_R  = 3'd4
  } state_t;

  typedef enum logic {
    GRANT_IFU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_t;

  state_t state;
  grant_t last_grant;

  // -------------------------------------------------------------------------
  // State register and round-robin bookkeeping.
  // last_grant resets to LSU so that a simultaneous first request goes to the
  // IFU. It is updated whenever a master is granted, contended or not, so the
  // next tie always goes to the other master.
  // A reset in the middle of a transaction simply returns to IDLE; whatever
  // the SRAM still has in flight is dropped, because the outputs are decoded
  // from the state and IDLE forwards nothing.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GRANT_LSU;
    end else begin
      case (state)
        IDLE: begin
          if (ifu_arvalid && lsu_arvalid) begin
            if (last_grant == GRANT_LSU) begin
              state      <= IFU_AR;
              last_grant <= GRANT_IFU;
            end else begin
              state      <= LSU_AR;
              last_grant <= GRANT_LSU;
            end
          end else if (ifu_arvalid) begin
            state      <= IFU_AR;
            last_grant <= GRANT_IFU;
          end else if (lsu_arvalid) begin
            state      <= LSU_AR;
            last_grant <= GRANT_LSU;
          end
        end

        // A master that withdraws arvalid before the SRAM accepted it breaks
        // the protocol; give the port back without issuing anything.
        IFU_AR: begin
          if (!ifu_arvalid) begin
            state <= IDLE;
          end else if (sram_arready) begin
            state <= IFU_R;
          end
        end

        IFU_R: begin
          if (sram_rvalid && ifu_rready) begin
            state <= IDLE;
          end
        end

        LSU_AR: begin
          if (!lsu_arvalid) begin
            state <= IDLE;
          end else if (sram_arready) begin
            state <= LSU_R;
          end
        end

        LSU_R: begin
          if (sram_rvalid && lsu_rready) begin
            state <= IDLE;
          end
        end

        // Unreachable encodings recover to IDLE.
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Channel steering. Everything defaults to zero, which is exactly what the
  // non-granted master and IDLE must see; each state then connects only the
  // channel it owns. sram_arvalid can therefore only be high in an AR state
  // and sram_rready only in an R state. rresp is passed through untouched,
  // error codes included.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output receives a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    ifu_arready  = 1'b0;
    ifu_rdata    = '0;
    ifu_rvalid   = 1'b0;
    ifu_rresp    = 2'b00;
    lsu_arready  = 1'b0;
    lsu_rdata    = '0;
    lsu_rvalid   = 1'b0;
    lsu_rresp    = 2'b00;
    sram_araddr  = '0;
    sram_arvalid = 1'b0;
    sram_rready  = 1'b0;

    case (state)
      IFU_AR: begin
        sram_araddr  = ifu_araddr;
        sram_arvalid = ifu_arvalid;
        ifu_arready  = sram_arready;
      end

      IFU_R: begin
        ifu_rdata   = sram_rdata;
        ifu_rresp   = sram_rresp;
        ifu_rvalid  = sram_rvalid;
        sram_rready = ifu_rready;
      end

      LSU_AR: begin
        sram_araddr  = lsu_araddr;
        sram_arvalid = lsu_arvalid;
        lsu_arready  = sram_arready;
      end

      LSU_R: begin
        lsu_rdata   = sram_rdata;
        lsu_rresp   = sram_rresp;
        lsu_rvalid  = sram_rvalid;
        sram_rready = lsu_rready;
      end

      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060208_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_23060208_mem_arbiter.
//
// Bench-side agents: two AXI-lite read masters (index 0 = IFU, 1 = LSU) that
// work through address lists, and an SRAM slave with configurable or random
// accept/response delays whose data and response are a fixed function of the
// address. A transaction-level reference model runs on every falling edge: it
// tracks which master currently owns the port and in which phase, applies
// the round-robin rule when the port is free, and checks the arbiter's
// outputs against that. Masters additionally score returned data against the
// SRAM address function in request order.
// ---------------------------------------------------------------------------
module tb_ysyx_23060208_mem_arbiter;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // master-side signals, index 0 = IFU, 1 = LSU
  logic [DW-1:0] m_araddr  [0:1];
  logic          m_arvalid [0:1];
  logic          m_rready  [0:1];
  logic          o_arready [0:1];
  logic [DW-1:0] o_rdata   [0:1];
  logic          o_rvalid  [0:1];
  logic [1:0]    o_rresp   [0:1];

  logic [DW-1:0] sram_araddr, sram_rdata;
  logic          sram_arvalid, sram_arready, sram_rvalid, sram_rready;
  logic [1:0]    sram_rresp;

  ysyx_23060208_mem_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_araddr   (m_araddr[0]),
    .ifu_arvalid  (m_arvalid[0]),
    .ifu_arready  (o_arready[0]),
    .ifu_rdata    (o_rdata[0]),
    .ifu_rvalid   (o_rvalid[0]),
    .ifu_rresp    (o_rresp[0]),
    .ifu_rready   (m_rready[0]),
    .lsu_araddr   (m_araddr[1]),
    .lsu_arvalid  (m_arvalid[1]),
    .lsu_arready  (o_arready[1]),
    .lsu_rdata    (o_rdata[1]),
    .lsu_rvalid   (o_rvalid[1]),
    .lsu_rresp    (o_rresp[1]),
    .lsu_rready   (m_rready[1]),
    .sram_araddr  (sram_araddr),
    .sram_arvalid (sram_arvalid),
    .sram_arready (sram_arready),
    .sram_rdata   (sram_rdata),
    .sram_rvalid  (sram_rvalid),
    .sram_rresp   (sram_rresp),
    .sram_rready  (sram_rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- agents
  logic [31:0] m_todo [0:1][$];   // addresses still to request
  logic [31:0] m_wait [0:1][$];   // accepted addresses awaiting data
  bit          m_req      [0:1];
  int          m_rr_hold  [0:1];  // cycles rready stays low after rvalid
  int          m_rv_cnt   [0:1];
  int          m_done     [0:1];
  int          m_ar_cyc   [0:1];
  int          m_r_cyc    [0:1];
  logic [1:0]  m_last_resp[0:1];
  bit          prev_r_pend[0:1];
  logic [31:0] prev_rdata [0:1];
  int          m_gap_pct, m_rr_pct;

  bit          s_busy;
  logic [31:0] s_addr;
  int          s_cnt, s_delay, s_ar_wait, s_ar_need;
  int          ar_delay_cfg, r_delay_cfg;
  bit          rnd_delays;
  bit          use_forced;
  logic [31:0] forced_data;
  logic [1:0]  forced_resp;
  bit          prev_ar_pend;
  logic [31:0] prev_sram_addr;

  int          grant_log[$];
  logic [31:0] sram_log[$];
  int          hold_err;
  int          cyc = 0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return use_forced ? forced_data : ((a * 32'h9E37_79B1) ^ 32'h0F0F_1234);
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    if (use_forced) return forced_resp;
    case (a[6:4])
      3'd7:    return 2'b10;
      3'd6:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic cfg_sram(input int ar_d, input int r_d);
    ar_delay_cfg = ar_d;
    r_delay_cfg  = r_d;
    s_ar_need    = ar_d;
  endtask

  // Observe handshakes of the current cycle (falling edge).
  task automatic sample();
    logic [31:0] a;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        if (prev_r_pend[i] && (o_rvalid[i] !== 1'b1 || o_rdata[i] !== prev_rdata[i])) hold_err++;
        if (m_arvalid[i] && o_arready[i]) begin
          m_wait[i].push_back(m_araddr[i]);
          void'(m_todo[i].pop_front());
          m_req[i]    = 1'b0;
          m_ar_cyc[i] = cyc;
        end
        if (o_rvalid[i] && m_rready[i]) begin
          if (m_wait[i].size() == 0) begin
            check(i == 0 ? "ifu_unexpected_r" : "lsu_unexpected_r", 1, 0);
          end else begin
            a = m_wait[i].pop_front();
            check(i == 0 ? "ifu_rdata" : "lsu_rdata", o_rdata[i], data_of(a));
            check(i == 0 ? "ifu_rresp" : "lsu_rresp", o_rresp[i], resp_of(a));
          end
          m_done[i]++;
          m_r_cyc[i]      = cyc;
          m_last_resp[i]  = o_rresp[i];
          m_rv_cnt[i]     = 0;
        end else if (o_rvalid[i]) begin
          m_rv_cnt[i]++;
        end
        prev_r_pend[i] = o_rvalid[i] && !m_rready[i];
        prev_rdata[i]  = o_rdata[i];
      end
      if (prev_ar_pend && (!sram_arvalid || sram_araddr !== prev_sram_addr)) hold_err++;
      prev_ar_pend   = sram_arvalid && !sram_arready;
      prev_sram_addr = sram_araddr;
      // R side first, so a fresh AR handshake below starts its own count.
      if (s_busy && sram_rvalid && sram_rready) s_busy = 1'b0;
      else if (s_busy && !sram_rvalid) s_cnt++;
      if (sram_arvalid && sram_arready) begin
        sram_log.push_back(sram_araddr);
        grant_log.push_back((o_arready[0] && m_arvalid[0]) ? 0 : 1);
        s_busy    = 1'b1;
        s_addr    = sram_araddr;
        s_cnt     = 0;
        s_ar_wait = 0;
        s_delay   = rnd_delays ? int'($urandom_range(0, 3)) : r_delay_cfg;
        s_ar_need = rnd_delays ? int'($urandom_range(0, 3)) : ar_delay_cfg;
      end else if (sram_arvalid) begin
        s_ar_wait++;
      end
    end
  endtask

  // Drive inputs for the next cycle (just after the rising edge).
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (!m_req[i] && m_todo[i].size() > 0 && m_wait[i].size() == 0 &&
          int'($urandom_range(0, 99)) < m_gap_pct) m_req[i] = 1'b1;
      m_arvalid[i] = m_req[i];
      m_araddr[i]  = m_req[i] ? m_todo[i][0] : $urandom;
      m_rready[i]  = (m_rv_cnt[i] >= m_rr_hold[i]) && (int'($urandom_range(0, 99)) < m_rr_pct);
    end
    sram_arready = !s_busy && (s_ar_wait >= s_ar_need);
    sram_rvalid  = s_busy && (s_cnt >= s_delay);
    sram_rdata   = sram_rvalid ? data_of(s_addr) : $urandom;
    sram_rresp   = sram_rvalid ? resp_of(s_addr) : 2'($urandom);
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  // ------------------------------------------------------ reference model
  // own: -1 = port free, 0 = IFU, 1 = LSU; own_r: data phase reached.
  bit model_en = 1'b0;
  int own      = -1;
  bit own_r    = 1'b0;
  int last     = 1;

  always @(negedge clk) begin
    if (model_en) begin
      if (own < 0) begin
        check("idle_ctrl", {o_arready[0], o_arready[1], o_rvalid[0], o_rvalid[1], sram_arvalid,
                            sram_rready, o_rresp[0], o_rresp[1]}, 64'd0);
        check("idle_data", {o_rdata[0], o_rdata[1]}, 64'd0);
        check("idle_addr", sram_araddr, 64'd0);
        if (m_arvalid[0] && m_arvalid[1]) own = 1 - last;
        else if (m_arvalid[0])            own = 0;
        else if (m_arvalid[1])            own = 1;
        if (own >= 0) begin
          last  = own;
          own_r = 1'b0;
        end
      end else begin
        check("other_quiet", {o_arready[1-own], o_rvalid[1-own], o_rresp[1-own], o_rdata[1-own]}, 64'd0);
        if (!own_r) begin
          check("ar_addr", sram_araddr, m_araddr[own]);
          check("ar_ctrl", {sram_arvalid, o_arready[own], o_rvalid[own], sram_rready},
                           {m_arvalid[own], sram_arready, 2'b00});
          if (!m_arvalid[own])  own   = -1;
          else if (sram_arready) own_r = 1'b1;
        end else begin
          check("r_ctrl", {o_rvalid[own], sram_rready, o_arready[own], sram_arvalid},
                          {sram_rvalid, m_rready[own], 2'b00});
          check("r_data", {o_rdata[own], o_rresp[own]}, {sram_rdata, sram_rresp});
          if (sram_rvalid && m_rready[own]) own = -1;
        end
      end
      if (!rst) begin
        own  = -1;
        last = 1;
      end
    end
  end

  // ------------------------------------------------------------- helpers
  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_todo[i].delete();
      m_wait[i].delete();
      m_req[i]       = 1'b0;
      m_rv_cnt[i]    = 0;
      m_done[i]      = 0;
      m_rr_hold[i]   = 0;
      prev_r_pend[i] = 1'b0;
      m_ar_cyc[i]    = -1;
      m_r_cyc[i]     = -1;
    end
    s_busy = 1'b0; s_cnt = 0; s_ar_wait = 0; s_delay = 0; prev_ar_pend = 1'b0;
    grant_log.delete();
    sram_log.delete();
    hold_err   = 0;
    m_gap_pct  = 100;
    m_rr_pct   = 100;
    rnd_delays = 1'b0;
    use_forced = 1'b0;
    cfg_sram(0, 0);
    step();
    model_en = 1'b1;
    step();
    rst = 1'b1;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n = 0;
    while ((m_todo[0].size() > 0 || m_todo[1].size() > 0 || m_wait[0].size() > 0 ||
            m_wait[1].size() > 0 || m_req[0] || m_req[1]) && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) check({tag, "_timeout"}, n, 0);
    step();
    step();
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    int c0;
    for (int i = 0; i < 2; i++) begin
      m_arvalid[i] = 1'b0; m_araddr[i] = '0; m_rready[i] = 1'b0;
    end
    sram_arready = 1'b0; sram_rvalid = 1'b0; sram_rdata = '0; sram_rresp = 2'b00;
    forced_data = '0; forced_resp = 2'b00;
    rst = 1'b0;

    // Lone IFU read: request in IDLE, arready next cycle, data the cycle after.
    do_reset();
    use_forced = 1'b1; forced_data = 32'h0000_0413; forced_resp = 2'b00;
    c0 = cyc;
    m_todo[0].push_back(32'h8000_0000);
    drain("t1", 50);
    check("t1_ar_cycle", m_ar_cyc[0] - c0, 2);
    check("t1_r_cycle", m_r_cyc[0] - c0, 3);
    check("t1_lsu_done", m_done[1], 0);
    check("t1_sram_addr", sram_log.size() > 0 ? sram_log[0] : 32'hDEAD_BEEF, 32'h8000_0000);

    // Simultaneous requests right after reset: IFU first, LSU right after.
    do_reset();
    c0 = cyc;
    m_todo[0].push_back(32'h8000_0004);
    m_todo[1].push_back(32'h8000_1000);
    drain("t2", 50);
    check("t2_n_ar", sram_log.size(), 2);
    if (sram_log.size() == 2) begin
      check("t2_addr0", sram_log[0], 32'h8000_0004);
      check("t2_addr1", sram_log[1], 32'h8000_1000);
    end
    check("t2_lsu_ar_cycle", m_ar_cyc[1] - c0, 5);
    check("t2_lsu_r_cycle", m_r_cyc[1] - c0, 6);

    // Continuous contention: strict alternation, one transaction per 3 cycles.
    do_reset();
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      m_todo[0].push_back(32'h8000_0100 + 32'(k * 4));
      m_todo[1].push_back(32'h8000_2000 + 32'(k * 4));
    end
    drain("t3", 100);
    check("t3_n_grants", grant_log.size(), 6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) check("t3_grant", grant_log[k], k % 2);
    check("t3_last_r_cycle", m_r_cyc[1] - c0, 18);

    // Slave stalls plus master back-pressure.
    do_reset();
    cfg_sram(3, 4);
    m_rr_hold[0] = 2;
    c0 = cyc;
    m_todo[0].push_back(32'h8000_0040);
    drain("t4", 100);
    check("t4_ar_cycle", m_ar_cyc[0] - c0, 5);
    check("t4_r_cycle", m_r_cyc[0] - c0, 12);
    check("t4_n_ar", sram_log.size(), 1);
    check("t4_held", hold_err, 0);

    // Error response is forwarded as-is.
    do_reset();
    use_forced = 1'b1; forced_data = 32'hCAFE_0001; forced_resp = 2'b10;
    c0 = cyc;
    m_todo[1].push_back(32'h8000_3000);
    drain("t5", 50);
    check("t5_rresp", m_last_resp[1], 2'b10);
    check("t5_r_cycle", m_r_cyc[1] - c0, 3);

    // Reset while LSU_R is waiting on the slave.
    do_reset();
    cfg_sram(0, 3);
    m_todo[1].push_back(32'h8000_4000);
    step(); step(); step();
    rst = 1'b0;
    s_delay = 0;          // slave answers right after the reset edge
    step();
    #2;
    check("t6_rst_ctrl", {o_arready[0], o_arready[1], o_rvalid[0], o_rvalid[1], sram_arvalid,
                          sram_rready, o_rresp[0], o_rresp[1]}, 64'd0);
    check("t6_rst_data", {o_rdata[1], sram_araddr}, 64'd0);
    rst = 1'b1;
    step();
    check("t6_no_forward", m_done[1], 0);
    s_busy = 1'b0;
    m_wait[1].delete();
    m_todo[0].push_back(32'h8000_0080);
    drain("t6", 50);
    check("t6_ifu_after_rst", m_done[0], 1);

    // Randomized traffic with random stalls and error codes.
    do_reset();
    rnd_delays = 1'b1;
    s_ar_need  = 1;
    m_gap_pct  = 60;
    m_rr_pct   = 70;
    for (int k = 0; k < 120; k++) begin
      m_todo[0].push_back($urandom & 32'hFFFF_FFFC);
      m_todo[1].push_back($urandom & 32'hFFFF_FFFC);
    end
    drain("rand", 20000);
    check("rand_ifu_done", m_done[0], 120);
    check("rand_lsu_done", m_done[1], 120);
    check("rand_held", hold_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060208_mem_arbiter.md
Name: ysyx_23060208_mem_arbiter

Overview:
- Two-master, one-slave read arbiter.
- Shares the single instruction/data SRAM read port between the IFU fetch path and the LSU load path.
- Sits between both masters' AXI-lite read channels (AR + R) and the SRAM read channel.
- Supports one outstanding transaction at a time, with round-robin grant on contention.

Parameters:
- DATA_WIDTH, 32, address and read-data width of all channels.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- ifu_araddr  in  DATA_WIDTH  IFU read address
- ifu_arvalid  in  1  IFU read request
- ifu_arready  out  1  IFU request accepted
- ifu_rdata  out  DATA_WIDTH  read data to IFU
- ifu_rvalid  out  1  read data valid to IFU
- ifu_rresp  out  2  response code to IFU
- ifu_rready  in  1  IFU accepts data
- lsu_araddr  in  DATA_WIDTH  LSU read address
- lsu_arvalid  in  1  LSU read request
- lsu_arready  out  1  LSU request accepted
- lsu_rdata  out  DATA_WIDTH  read data to LSU
- lsu_rvalid  out  1  read data valid to LSU
- lsu_rresp  out  2  response code to LSU
- lsu_rready  in  1  LSU accepts data
- sram_araddr  out  DATA_WIDTH  address to SRAM
- sram_arvalid  out  1  request to SRAM
- sram_arready  in  1  SRAM accepts request
- sram_rdata  in  DATA_WIDTH  SRAM read data
- sram_rvalid  in  1  SRAM data valid
- sram_rresp  in  2  SRAM response code
- sram_rready  out  1  ready toward SRAM

Behaviour:
- FSM states: IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R. The FSM is registered, and the grant is held in the state.
- Reset (rst==0 at a clk edge):
  - state=IDLE, last_grant=LSU.
  - All outputs are 0: arready, rvalid, sram_arvalid, sram_rready, rdata, rresp, sram_araddr.
  - Reset mid-transaction abandons it. The slave response is not forwarded.
- IDLE:
  - Only ifu_arvalid -> IFU_AR.
  - Only lsu_arvalid -> LSU_AR.
  - Both asserted -> grant the master that is not last_grant, and update last_grant on entering the AR state.
  - Neither -> stay in IDLE.
  - All handshake outputs are 0 in IDLE, so arbitration costs one cycle: the request is seen in IDLE and forwarded on the next cycle.
- X_AR (X = granted master), combinational pass-through:
  - sram_araddr = x_araddr.
  - sram_arvalid = x_arvalid.
  - x_arready = sram_arready.
  - Other master's arready = 0.
  - On sram_arvalid && sram_arready -> X_R.
  - If x_arvalid drops before handshake (protocol violation) -> IDLE, no transaction issued.
- X_R:
  - x_rdata = sram_rdata, x_rresp = sram_rresp, x_rvalid = sram_rvalid, sram_rready = x_rready.
  - On sram_rvalid && x_rready -> IDLE.
  - rresp is passed unmodified (SLVERR/DECERR forwarded, no retry).
- Non-granted master at all times:
  - arready=0, rvalid=0, rdata=0, rresp=0.
  - Its arvalid may stay high indefinitely without side effect.
- sram_arvalid is never high outside an AR state. sram_rready is never high outside an R state.
- Back-to-back throughput: at most one transaction per 3 cycles with a zero-latency slave (IDLE, AR, R).
- The IFU-to-LSU request sequence from the same master is unaffected by the other master beyond the wait for the current transaction. No starvation: under continuous contention the grants strictly alternate.
- Address and data are not registered. The arbiter adds no latency except the IDLE cycle.

Test Plan:
- Lone IFU read:
  - Stimulus: ifu_araddr=0x80000000, arvalid held; SRAM arready=1 and rvalid=1 next cycle, rdata=0x00000413.
  - Required: ifu_arready pulses in cycle 2, ifu_rdata=0x00000413 with ifu_rvalid, lsu_rvalid stays 0, FSM back to IDLE.
- Simultaneous requests after reset:
  - Stimulus: IFU addr 0x80000004 and LSU addr 0x80001000 asserted in the same cycle.
  - Required: IFU is served first (last_grant reset=LSU), then the LSU transaction starts immediately after IFU_R completes. sram_araddr sequence is 0x80000004, 0x80001000.
- Continuous contention:
  - Stimulus: both arvalid held high for 6 transactions.
  - Required: grants alternate IFU, LSU, IFU, LSU, IFU, LSU. Neither master waits more than one transaction.
- Slave stalls:
  - Stimulus: sram_arready delayed 3 cycles, sram_rvalid delayed 4 cycles, ifu_rready=0 for 2 cycles after rvalid.
  - Required: sram_araddr stable throughout AR, data held until ifu_rready=1, a single transaction, correct rdata.
- Error response:
  - Stimulus: sram_rresp=2'b10 on an LSU read.
  - Required: lsu_rresp=2'b10 with lsu_rvalid, FSM returns to IDLE.
- Reset mid-transaction:
  - Stimulus: rst=0 while in LSU_R.
  - Required: next cycle state=IDLE, all outputs 0, the late sram_rvalid is not forwarded. After rst=1 a new IFU request is served normally.
